// File: rtl/systolic_result_drain_pkg.sv
// Shared constants and state type for the systolic result drain.
package systolic_result_drain_pkg;

    localparam int N   = 4;
    localparam int M   = 18;
    localparam int WIN = 2 * N - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/systolic_result_drain_skew_delay_line.sv
// Fixed-length register chain used to undo the diagonal skew of one column.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign o_q      = i_d;
    end else begin : g_chain
        logic [W-1:0] r_stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            end else begin
                r_stage[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Re-aligns skewed PE-array column outputs into whole rows and buffers them behind valid/ready.
module systolic_result_drain
    import systolic_result_drain_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*M-1:0] col_data,
    output logic           busy,
    output logic           start_err,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*M-1:0] out_row,
    output logic           out_last
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int WW = $clog2(WIN);

    logic [N*M-1:0] w_aligned;

    // Column c is delayed N-1-c cycles so every column's row r lands together.
    for (genvar c = 0; c < N; c++) begin : g_col
        skew_delay_line #(
            .DEPTH(N - 1 - c),
            .W    (M)
        ) u_dly (
            .clk(clk),
            .rst(rst),
            .i_d(col_data[c*M +: M]),
            .o_q(w_aligned[c*M +: M])
        );
    end

    state_t         r_state;
    logic [WW-1:0]  r_win;
    logic           r_err;
    logic [N*M-1:0] r_mem [N];
    logic [N-1:0]   r_last_mem;
    logic [PW-1:0]  r_rd;
    logic [PW-1:0]  r_wr;
    logic [CW-1:0]  r_cnt;

    logic           w_win_end;
    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_cnt_nxt;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    // Aligned rows exist from window offset N-1 onward; the final offset carries row N-1.
    assign w_win_end = (r_win == WW'(WIN - 1));
    assign w_push    = (r_state == CAPTURE) && (r_win >= WW'(N - 1));
    assign out_valid = (r_cnt != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_win   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CAPTURE;
                        r_win   <= '0;
                    end
                end
                CAPTURE: begin
                    if (w_win_end) begin
                        r_win   <= '0;
                        r_state <= (w_cnt_nxt == '0) ? IDLE : DRAIN;
                    end else begin
                        r_win <= r_win + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_cnt_nxt == '0) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (start && (r_state != IDLE)) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_last_mem <= '0;
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr]      <= w_aligned;
                r_last_mem[r_wr] <= w_win_end;
                r_wr             <= nxt_ptr(r_wr);
            end
            if (w_pop) r_rd <= nxt_ptr(r_rd);
            r_cnt <= w_cnt_nxt;
        end
    end

    assign busy      = (r_state != IDLE);
    assign start_err = r_err;
    assign out_row   = out_valid ? r_mem[r_rd] : '0;
    assign out_last  = out_valid & r_last_mem[r_rd];

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized scoreboard bench for systolic_result_drain.
module tb_systolic_result_drain;
    import systolic_result_drain_pkg::*;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           start     = 1'b0;
    logic           out_ready = 1'b0;
    logic [N*M-1:0] col_data  = '0;
    logic           busy;
    logic           start_err;
    logic           out_valid;
    logic           out_last;
    logic [N*M-1:0] out_row;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        logic [N*M-1:0] row;
        logic           last;
        int             cyc;
    } exp_t;

    exp_t exp_q[$];

    systolic_result_drain dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .col_data (col_data),
        .busy     (busy),
        .start_err(start_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_last (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [N*M-1:0] act,
                                input logic [N*M-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    logic           prev_stall = 1'b0;
    logic [N*M-1:0] prev_row   = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_row", out_row, prev_row);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_row: got %h expected no row", out_row);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("row", out_row, e.row);
                    chk("last", out_last, e.last);
                    if (e.cyc >= 0) chk("row_cycle", cyc, e.cyc);
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_row   <= out_row;
        end
    end

    // mode 0: ready always 1; mode 1: ready 0 until k=hold; mode 2: ready toggles 1,0,1,0.
    task automatic run_block(input int mode, input int hold, input bit pattern, input int err_k,
                             input int rst_k, input int ncyc, input bit expect_err);
        logic [M-1:0]   mat [N][N];
        logic [N*M-1:0] rowv;
        exp_t           e;
        int             s;
        int             lp;
        s  = cyc;
        lp = (mode == 0) ? 2 * N : ((mode == 1) ? hold + N - 1 : -1);
        chk("idle_before_start", busy, 0);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                mat[r][c] = pattern ? M'(16 * r + c) : M'($urandom());
                rowv[c*M +: M] = mat[r][c];
            end
            e.row  = rowv;
            e.last = (r == N - 1);
            e.cyc  = (mode == 0) ? s + N + 1 + r : ((mode == 1) ? s + hold + r : -1);
            exp_q.push_back(e);
        end
        for (int k = 0; k < ncyc; k++) begin
            start = (k == 0) || (k == err_k);
            for (int c = 0; c < N; c++) begin
                int r;
                r = k - 1 - c;
                col_data[c*M +: M] = (r >= 0 && r < N) ? mat[r][c] : M'($urandom());
            end
            out_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? (k >= hold) : (k % 2 == 0));
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_start_err", start_err, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_row", out_row, 0);
                chk("rst_last", out_last, 0);
                exp_q.delete();
            end
            if (k == rst_k + 1) rst = 1'b0;
            if (rst_k >= 0 && k > rst_k) begin
                chk("valid_after_rst", out_valid, 0);
                chk("busy_after_rst", busy, 0);
            end
            if (rst_k < 0) begin
                if (k == N) chk("valid_before_row0", out_valid, 0);
                if (k == N + 1) chk("valid_row0", out_valid, 1);
                if (lp >= 0 && k == lp) chk("busy_at_last_pop", busy, 1);
                if (lp >= 0 && k == lp + 1) chk("busy_fall", busy, 0);
            end
            if (err_k >= 0 && k > err_k) chk("start_err_sticky", start_err, 1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (rst_k < 0) chk("drained", exp_q.size(), 0);
        chk("start_err_end", start_err, expect_err);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_start_err", start_err, 0);
        chk("init_valid", out_valid, 0);
        chk("init_row", out_row, 0);
        chk("init_last", out_last, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_block(0, 0, 1'b1, -1, -1, 2 * N + 3, 1'b0);
        run_block(1, 3 * N, 1'b0, -1, -1, 4 * N + 2, 1'b0);
        run_block(2, 0, 1'b0, -1, -1, 4 * N + 6, 1'b0);
        run_block(0, 0, 1'b0, 3, -1, 2 * N + 3, 1'b1);
        run_block(0, 0, 1'b0, -1, 4, 10, 1'b0);
        run_block(0, 0, 1'b0, -1, -1, 2 * N + 3, 1'b0);
        run_block(0, 0, 1'b0, -1, -1, 2 * N + 1, 1'b0);
        run_block(0, 0, 1'b0, -1, -1, 2 * N + 3, 1'b0);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
